// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle unsigned adder for two 4*NIBBLES-bit operands. It processes one
// 4-bit slice per clock through a two-level carry-lookahead slice. The carry
// between slices is held in a register, so the critical path is one slice wide
// whatever NIBBLES is.
//
// Transaction flow: IDLE (accept) -> ADD (NIBBLES cycles) -> DONE (hold until
// out_ready). The result is {carry_out, sum} = in_a + in_b + in_cin.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair and in_cin valid
//   in_ready   block can accept an operand pair (state IDLE)
//   in_a/in_b  unsigned operands, W = 4*NIBBLES bits
//   in_cin     carry into nibble 0
//   out_valid  out_sum holds a completed result (state DONE)
//   out_ready  consumer accepts out_sum
//   out_sum    W+1-bit result {carry_out, sum[W-1:0]}
//   busy       high while the adder is stepping through nibbles (state ADD)
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES:0]   out_sum,
    output logic                 busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [W:0]       sum_r;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;

    // 4-bit lookahead slice. Every carry is a flat sum of products of the
    // generate/propagate terms and c0; no carry depends on a lower carry.
    // Returns {c4, s[3:0]}.
    function automatic logic [4:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a | b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    // Outputs are decoded from the registered state only.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == ADD);
    assign out_sum   = sum_r;

    // Select the current nibble of each operand and run it through the slice.
    // The mux is an OR of one-hot masked nibbles so no part-select index is
    // computed from idx_r.
    always_comb begin
        a_nib_s = 4'd0;
        b_nib_s = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            a_nib_s = a_nib_s | ((idx_r == IDX_W'(n)) ? a_r[4*n +: 4] : 4'd0);
            b_nib_s = b_nib_s | ((idx_r == IDX_W'(n)) ? b_r[4*n +: 4] : 4'd0);
        end
        slice_s = cla4(a_nib_s, b_nib_s, carry_r);
    end

    // Next-state decode for the IDLE/ADD/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, per-nibble result write and inter-slice carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                ADD: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx_r == IDX_W'(n)) begin
                            sum_r[4*n +: 4] <= slice_s[3:0];
                        end
                    end
                    carry_r <= slice_s[4];
                    // idx_r stops at the last nibble instead of wrapping.
                    if (idx_r == IDX_LAST) begin
                        sum_r[W] <= slice_s[4];
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE holds the result; nothing to update.
                end
            endcase
        end
    end

endmodule
